// File: rtl/orth_dds.sv
// orth_dds -- quadrature direct digital synthesizer.
//
// A PW-bit phase accumulator advances by the signed word freq on every
// enabled clock. The accumulator plus the phase offset is truncated to an
// AW-bit table address k. The sine table lookup is registered onto sin, and
// the lookup at k + quarter turn is registered onto cos. The latency is one
// enabled cycle. The table is computed at elaboration from the parameters.
//
// Ports
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset (clears acc, sin, cos)
//   en     in   1   clock enable, one sample per enabled cycle
//   freq   in   PW  signed frequency word, fout = freq * fclk / 2^PW
//   phase  in   PW  phase offset, full turn = 2^PW
//   sin    out  DW  signed in-phase sample (registered)
//   cos    out  DW  signed quadrature sample (registered)
//
// Build option
//   ORTH_DDS_QUARTER_LUT_EN  when defined, only 2^(AW-2)+1 first-quadrant
//                            magnitudes are stored and the other quadrants
//                            are folded out of them. The output is
//                            bit-identical to the full-table build.
module orth_dds #(
    parameter int PW = 32,
    parameter int DW = 24,
    parameter int AW = 13
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [PW-1:0]        freq,
    input  logic [PW-1:0]        phase,
    output logic signed [DW-1:0] sin,
    output logic signed [DW-1:0] cos
);

    localparam int  Q  = 2 ** (AW - 2);
    localparam real FS = real'((2 ** (DW - 1)) - 1);
    localparam real PI = 3.14159265358979323846;

    // First-quadrant magnitude, rounded half away from zero (non-negative).
    function automatic int qmag(input int j);
        real x;
        x = FS * $sin(PI / 2.0 * real'(j) / real'(Q));
        return $rtoi(x + 0.5);
    endfunction

    // Both builds derive every entry from the same first-quadrant values.
    // This keeps the two builds bit-identical by construction.
    function automatic int sval(input int k);
        int quad;
        int off;
        quad = k / Q;
        off  = k % Q;
        case (quad)
            0:       return  qmag(off);
            1:       return  qmag(Q - off);
            2:       return -qmag(off);
            default: return -qmag(Q - off);
        endcase
    endfunction

    logic [PW-1:0]        acc;
    logic [AW-1:0]        k_sin;
    logic [AW-1:0]        k_cos;
    logic signed [DW-1:0] sin_nxt;
    logic signed [DW-1:0] cos_nxt;

    // The top AW bits of (acc + phase) are formed without building the full
    // PW-bit sum. The low-half carry is acc_lo + phase_lo >= 2^n, which
    // holds exactly when acc_lo > ~phase_lo.
    generate
        if (AW < PW) begin : g_carry
            logic carry;
            assign carry = acc[PW-AW-1:0] > ~phase[PW-AW-1:0];
            assign k_sin = acc[PW-1 -: AW] + phase[PW-1 -: AW] + AW'(carry);
        end else begin : g_nocarry
            assign k_sin = acc + phase;
        end
    endgenerate

    assign k_cos = k_sin + AW'(Q);

`ifdef ORTH_DDS_QUARTER_LUT_EN
    logic signed [DW-1:0] qlut [Q+1];

    for (genvar j = 0; j <= Q; j++) begin : g_qlut
        assign qlut[j] = DW'(qmag(j));
    end

    // Quadrants 1 and 3 mirror the offset. Quadrants 2 and 3 negate.
    function automatic logic signed [DW-1:0] fold(input logic [AW-1:0] k);
        logic [AW-2:0] idx;
        idx = k[AW-2] ? ((AW-1)'(Q) - {1'b0, k[AW-3:0]}) : {1'b0, k[AW-3:0]};
        return k[AW-1] ? -qlut[idx] : qlut[idx];
    endfunction

    always_comb begin
        sin_nxt = fold(k_sin);
        cos_nxt = fold(k_cos);
    end
`else
    logic signed [DW-1:0] lut [2**AW];

    for (genvar i = 0; i < 2 ** AW; i++) begin : g_lut
        assign lut[i] = DW'(sval(i));
    end

    always_comb begin
        sin_nxt = lut[k_sin];
        cos_nxt = lut[k_cos];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            sin <= '0;
            cos <= '0;
        end else if (en) begin
            acc <= acc + freq;
            sin <= sin_nxt;
            cos <= cos_nxt;
        end
    end

endmodule

// File: tb/tb_orth_dds.sv
// Self-checking bench for orth_dds (PW=32, DW=12, AW=13, full scale 2047).
module tb_orth_dds;

    localparam real PI = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               en = 1'b0;
    logic [31:0]        freq = '0;
    logic [31:0]        phase = '0;
    logic signed [11:0] s_out;
    logic signed [11:0] c_out;

    int total = 0;
    int bad = 0;

    orth_dds #(.PW(32), .DW(12), .AW(13)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .freq  (freq),
        .phase (phase),
        .sin   (s_out),
        .cos   (c_out)
    );

    always #5 clk = ~clk;

    // Ideal table value straight from the sine definition.
    function automatic int smod(input int k);
        real x;
        x = 2047.0 * $sin(2.0 * PI * real'(k) / 8192.0);
        if (x >= 0.0) return $rtoi($floor(x + 0.5));
        else          return -$rtoi($floor(-x + 0.5));
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: phase arithmetic on plain 32-bit words.
    logic [31:0] acc_m = '0;
    int          exp_sin = 0;
    int          exp_cos = 0;
    bit          m_valid = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] theta;
        int          k;
        if (!rst_n) begin
            acc_m   = '0;
            exp_sin = 0;
            exp_cos = 0;
            m_valid = 1'b0;
        end else if (en) begin
            theta   = acc_m + phase;
            k       = int'(theta >> 19);
            exp_sin = smod(k);
            exp_cos = smod((k + 2048) % 8192);
            acc_m   = acc_m + freq;
            m_valid = 1'b1;
        end
    end

    // Every-cycle comparison against the model, plus amplitude sanity.
    always @(negedge clk) begin
        int  s;
        int  c;
        real e;
        if (rst_n) begin
            s = s_out;
            c = c_out;
            chk("sin_vs_model", s, exp_sin);
            chk("cos_vs_model", c, exp_cos);
            if (m_valid) begin
                e = real'(s * s + c * c);
                total++;
                if (e < 0.99 * 2047.0 * 2047.0 || e > 1.01 * 2047.0 * 2047.0) begin
                    bad++;
                    $display("FAIL energy actual=%0d required=%0d+/-1%%", s * s + c * c, 2047 * 2047);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset away from the clock edge and checks that it acts at once.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("async_rst_sin", s_out, 0);
        chk("async_rst_cos", c_out, 0);
        step();
        rst_n = 1'b1;
    endtask

    int q_sin [4] = '{0, 2047, 0, -2047};
    int q_cos [4] = '{2047, 0, -2047, 0};
    int n_sin [4] = '{0, -2047, 0, 2047};
    bit st_en [5] = '{1, 0, 0, 1, 1};
    int st_sin [5] = '{0, 0, 0, 2047, 0};
    int st_cos [5] = '{2047, 2047, 2047, 0, -2047};

    initial begin
        longint f0;
        longint f1;
        int     rst_at;

        step();
        step();
        chk("reset_sin", s_out, 0);
        chk("reset_cos", c_out, 0);

        chk("model_s0", smod(0), 0);
        chk("model_s1024", smod(1024), 1447);
        chk("model_s2048", smod(2048), 2047);
        chk("model_s4096", smod(4096), 0);
        chk("model_s6144", smod(6144), -2047);

        // Zero frequency, zero phase.
        en = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dc_sin", s_out, 0);
            chk("dc_cos", c_out, 2047);
        end

        // Quarter-rate tone.
        freq = 32'h4000_0000;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("qrate_sin", s_out, q_sin[i % 4]);
            chk("qrate_cos", c_out, q_cos[i % 4]);
        end

        // Negative frequency.
        freq = 32'hC000_0000;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            chk("neg_sin", s_out, n_sin[i % 4]);
            chk("neg_cos", c_out, q_cos[i % 4]);
        end

        // Phase offset.
        freq = '0;
        phase = 32'h8000_0000;
        do_reset();
        step();
        chk("ph180_sin", s_out, 0);
        chk("ph180_cos", c_out, -2047);
        phase = 32'h4000_0000;
        step();
        chk("ph90_sin", s_out, 2047);
        chk("ph90_cos", c_out, 0);

        // Enable stall.
        freq = 32'h4000_0000;
        phase = '0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            en = st_en[i];
            step();
            chk("stall_sin", s_out, st_sin[i]);
            chk("stall_cos", c_out, st_cos[i]);
        end

        // Sweep from 1 MHz to 50 MHz at fclk = 100 MHz.
        en = 1'b1;
        f0 = 64'd42949673;
        f1 = 64'd2147483648;
        for (int i = 0; i < 2000; i++) begin
            freq = 32'(f0 + (f1 - f0) * i / 1999);
            step();
        end

        // Randomised frequency, phase and enable, with one mid-run reset.
        rst_at = 1000 + int'($urandom_range(0, 999));
        for (int i = 0; i < 3000; i++) begin
            if (i % 50 == 0) freq = $urandom;
            phase = $urandom;
            en = ($urandom % 4) != 0;
            if (i == rst_at) do_reset();
            else step();
        end

        en = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/orth_dds.md
ORTH_DDS -- requirements
Module: orth_dds

Interface
REQ-001 SHALL have parameter PW, default 32, meaning phase accumulator / frequency / phase word width.
REQ-002 SHALL have parameter DW, default 24, meaning signed output sample width.
REQ-003 SHALL have parameter AW, default 13, meaning LUT phase address width (2^AW points per cycle), 3 <= AW <= PW.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, clock enable; one sample produced per cycle with en=1.
REQ-007 SHALL have port freq, input, PW, signed two's-complement frequency control word (fout = freq*fclk/2^PW).
REQ-008 SHALL have port phase, input, PW, phase offset added to accumulator (full turn = 2^PW).
REQ-009 SHALL have port sin, output, DW, signed in-phase sample (registered).
REQ-010 SHALL have port cos, output, DW, signed quadrature sample (registered).
REQ-011 SHALL keep port order clk, rst_n, en, freq, phase, sin, cos, so positional instantiation with cos left open is valid.

Function
REQ-012 SHALL hold a PW-bit phase accumulator acc; on each rising edge with en=1, acc <= acc + freq modulo 2^PW (negative freq rotates backwards, wrap silent).
REQ-013 SHALL form theta = (acc + phase) modulo 2^PW from the pre-update acc value, address k = theta[PW-1:PW-AW] (truncation, no rounding, no dither).
REQ-014 SHALL, on each rising edge with en=1, register sin <= S(k), cos <= S((k + 2^(AW-2)) mod 2^AW).
REQ-015 SHALL define S(k) = round-half-away-from-zero((2^(DW-1)-1)*sin(2*pi*k/2^AW)); magnitude never exceeds 2^(DW-1)-1 (no -2^(DW-1) code).
REQ-016 SHALL compute the table at elaboration from parameters (no external memory file).
REQ-017 SHALL have latency of one enabled cycle: sample registered on an en edge reflects acc value before that edge; first sample after reset equals S(phase address).
REQ-018 SHALL hold acc, sin, cos unchanged on edges with en=0; freq/phase changes take effect on the next en edge.
REQ-019 SHALL be combinationally free between inputs and outputs.

Reset
REQ-020 SHALL, while rst_n=0, asynchronously force acc=0, sin=0, cos=0.
REQ-021 SHALL resume on the first rising edge with rst_n=1 and en=1, reset mid-operation discarding accumulated phase.

Configuration
REQ-022 SHALL honour macro ORTH_DDS_QUARTER_LUT_EN: when defined, store only 2^(AW-2)+1 first-quadrant magnitudes and derive all quadrants by address mirroring and sign inversion; when undefined, store the full 2^AW-entry signed table.
REQ-023 SHALL produce bit-identical sin/cos sequences with and without ORTH_DDS_QUARTER_LUT_EN.

Verification (PW=32, DW=12, AW=13, full scale 2047)
REQ-024 SHALL check reset: rst_n=0 asynchronously mid-run -> sin=0, cos=0 immediately; after release, freq=0, phase=0, en=1 -> sin=0, cos=2047 every cycle.
REQ-025 SHALL check quarter-rate tone: freq=2^30, phase=0, en=1 -> sin 0,2047,0,-2047,... and cos 2047,0,-2047,0,... repeating.
REQ-026 SHALL check negative freq wrap: freq=-2^30 -> sin 0,-2047,0,2047,...; cos 2047,0,-2047,0,...
REQ-027 SHALL check phase offset: freq=0, phase=2^31 -> sin=0, cos=-2047; phase=2^30 -> sin=2047, cos=0.
REQ-028 SHALL check enable stall: freq=2^30, en toggling 1,0,0,1 -> outputs and acc frozen during en=0, sequence resumes without skipped samples.
REQ-029 SHALL check sweep: freq ramp 1 MHz to 50 MHz at fclk=100 MHz -> every sample satisfies |sin|,|cos| <= 2047 and sin^2+cos^2 within 2047^2 +/- 1%, identical in both macro builds.
